// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - message-granular round-robin arbiter in front of a single UART byte transmitter
//
// Two producers (req0: assembler solution stream, req1: status/debug reporter)
// share one UART. Each producer owns a one-byte pending slot. A grant covers a
// whole message of BYTES_PER_MSG bytes, so bytes of different messages never
// interleave on the wire.
//
// Ports:
//   clk, rst                 system clock, asynchronous active-high reset
//   req0_send / req0_byte    requester 0 byte strobe and data
//   req0_done                one-cycle pulse when requester 0's byte has been sent
//   req1_send / req1_byte    requester 1 byte strobe and data
//   req1_done                one-cycle pulse when requester 1's byte has been sent
//   tx_send / tx_byte        launch strobe and registered byte to the UART
//   tx_done                  UART completion level (only rising edges count)
//   overflow                 sticky: a send arrived while that requester's slot was full
//   busy                     arbiter is not idle
module uart_tx_arbiter #(
    parameter int BYTES_PER_MSG = 2,
    parameter bit FIXED_PRIO    = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0_send,
    input  logic [7:0] req0_byte,
    output logic       req0_done,
    input  logic       req1_send,
    input  logic [7:0] req1_byte,
    output logic       req1_done,
    output logic       tx_send,
    output logic [7:0] tx_byte,
    input  logic       tx_done,
    output logic       overflow,
    output logic       busy
);

    localparam int CNT_W = (BYTES_PER_MSG > 1) ? $clog2(BYTES_PER_MSG) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BYTES_PER_MSG - 1);

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        WAIT_DONE,
        WAIT_NEXT
    } state_t;

    state_t           state;
    state_t           next_state;
    logic             owner;
    logic             next_owner;
    logic             rr_ptr;
    logic [CNT_W-1:0] byte_cnt;
    logic             tx_done_q;
    logic             done_edge;

    logic [7:0]       req_byte [2];
    logic [1:0]       send_vec;
    logic [7:0]       slot_byte [2];
    logic [1:0]       slot_valid;

    logic             launch_load;
    logic [1:0]       slot_clear;
    logic             byte_done;
    logic             msg_done;

    assign req_byte[0] = req0_byte;
    assign req_byte[1] = req1_byte;
    assign send_vec    = {req1_send, req0_send};

    // Only rising edges of the UART completion level count; a level held for
    // several cycles is one completion.
    assign done_edge = tx_done & ~tx_done_q;

    // Both outputs decode registered state only, so no input reaches them
    // combinationally.
    assign tx_send = (state == LAUNCH);
    assign busy    = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state  = state;
        next_owner  = owner;
        launch_load = 1'b0;
        slot_clear  = 2'b00;
        byte_done   = 1'b0;
        msg_done    = 1'b0;
        case (state)
            IDLE: begin
                if (|slot_valid) begin
                    next_state  = LAUNCH;
                    launch_load = 1'b1;
                    if (&slot_valid) begin
                        next_owner = FIXED_PRIO ? 1'b0 : rr_ptr;
                    end else begin
                        next_owner = slot_valid[1];
                    end
                end
            end
            LAUNCH: begin
                // The slot frees on leaving LAUNCH; a send landing on this
                // same edge is accepted rather than flagged.
                next_state = WAIT_DONE;
                slot_clear = owner ? 2'b10 : 2'b01;
            end
            WAIT_DONE: begin
                if (done_edge) begin
                    byte_done = 1'b1;
                    if (byte_cnt == LAST_CNT) begin
                        msg_done   = 1'b1;
                        next_state = IDLE;
                    end else begin
                        next_state = WAIT_NEXT;
                    end
                end
            end
            WAIT_NEXT: begin
                // Grant stays locked: only the owner's slot may launch.
                if (slot_valid[owner]) begin
                    next_state  = LAUNCH;
                    launch_load = 1'b1;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_done_q  <= 1'b0;
            owner      <= 1'b0;
            rr_ptr     <= 1'b0;
            byte_cnt   <= '0;
            tx_byte    <= 8'h00;
            req0_done  <= 1'b0;
            req1_done  <= 1'b0;
            overflow   <= 1'b0;
            slot_valid <= 2'b00;
            for (int i = 0; i < 2; i++) begin
                slot_byte[i] <= 8'h00;
            end
        end else begin
            tx_done_q <= tx_done;
            owner     <= next_owner;

            // tx_byte is loaded on entry to LAUNCH so it is already valid
            // while tx_send is high, and holds until the next launch.
            if (launch_load) begin
                tx_byte <= slot_byte[next_owner];
            end

            req0_done <= byte_done & ~owner;
            req1_done <= byte_done & owner;

            if (msg_done) begin
                byte_cnt <= '0;
                rr_ptr   <= ~owner;
            end else if (byte_done) begin
                byte_cnt <= byte_cnt + 1'b1;
            end

            for (int i = 0; i < 2; i++) begin
                if (send_vec[i]) begin
                    if (!slot_valid[i] || slot_clear[i]) begin
                        slot_byte[i]  <= req_byte[i];
                        slot_valid[i] <= 1'b1;
                    end else begin
                        overflow <= 1'b1;
                    end
                end else if (slot_clear[i]) begin
                    slot_valid[i] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - directed scoreboard bench for uart_tx_arbiter
module tb_uart_tx_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req0_send = 1'b0;
    logic [7:0] req0_byte = 8'h00;
    logic       req0_done;
    logic       req1_send = 1'b0;
    logic [7:0] req1_byte = 8'h00;
    logic       req1_done;
    logic       tx_send;
    logic [7:0] tx_byte;
    logic       tx_done = 1'b0;
    logic       overflow;
    logic       busy;

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .BYTES_PER_MSG (2),
        .FIXED_PRIO    (1'b0)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req0_send (req0_send),
        .req0_byte (req0_byte),
        .req0_done (req0_done),
        .req1_send (req1_send),
        .req1_byte (req1_byte),
        .req1_done (req1_done),
        .tx_send   (tx_send),
        .tx_byte   (tx_byte),
        .tx_done   (tx_done),
        .overflow  (overflow),
        .busy      (busy)
    );

    typedef struct packed {
        logic       req;
        logic [7:0] data;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   passed = 0;
    int   launch_cnt = 0;
    int   d0_cnt = 0;
    int   d1_cnt = 0;
    int   lat;
    int   base;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every launch pops the byte the bench queued for it.
    always @(negedge clk) begin
        if (!rst) begin
            if (tx_send) begin
                launch_cnt++;
                if (exp_q.size() == 0) begin
                    checks++;
                    $error("FAIL unexpected_tx_send observed=%02h expected=none", tx_byte);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("tx_byte", {24'h0, tx_byte}, {24'h0, mon_e.data});
                end
            end
            if (req0_done) d0_cnt++;
            if (req1_done) d1_cnt++;
        end
    end

    task automatic push(input logic r, input logic [7:0] b);
        exp_t e;
        e.req  = r;
        e.data = b;
        exp_q.push_back(e);
    endtask

    task automatic send1(input int r, input logic [7:0] b);
        @(negedge clk);
        if (r == 0) begin
            req0_send = 1'b1;
            req0_byte = b;
        end else begin
            req1_send = 1'b1;
            req1_byte = b;
        end
        @(negedge clk);
        req0_send = 1'b0;
        req1_send = 1'b0;
    endtask

    task automatic send_both(input logic [7:0] b0, input logic [7:0] b1);
        @(negedge clk);
        req0_send = 1'b1;
        req0_byte = b0;
        req1_send = 1'b1;
        req1_byte = b1;
        @(negedge clk);
        req0_send = 1'b0;
        req1_send = 1'b0;
    endtask

    task automatic wait_launch(input int target, output int cycles);
        cycles = 0;
        while (launch_cnt < target && cycles < 50) begin
            @(negedge clk);
            #1;
            cycles++;
        end
        if (launch_cnt < target) begin
            checks++;
            $error("FAIL launch_timeout observed=%0d expected=%0d", launch_cnt, target);
        end
    endtask

    task automatic pulse_done(input int hold, input int exp_d0, input int exp_d1, input string tag);
        int b0;
        int b1;
        b0 = d0_cnt;
        b1 = d1_cnt;
        @(negedge clk);
        tx_done = 1'b1;
        repeat (hold) @(negedge clk);
        tx_done = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check({tag, "_req0_done"}, d0_cnt - b0, exp_d0);
        check({tag, "_req1_done"}, d1_cnt - b1, exp_d1);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #12;
        check("rst_tx_send", tx_send, 0);
        check("rst_tx_byte", tx_byte, 0);
        check("rst_done", {req1_done, req0_done}, 0);
        check("rst_overflow", overflow, 0);
        check("rst_busy", busy, 0);
        @(negedge clk);
        rst = 1'b0;

        // 1: two bytes from req0, one per done
        push(1'b0, 8'h02);
        send1(0, 8'h02);
        wait_launch(1, lat);
        check("s1_latency", lat, 1);
        check("s1_busy", busy, 1);
        pulse_done(1, 1, 0, "s1_b1");
        push(1'b0, 8'h03);
        send1(0, 8'h03);
        wait_launch(2, lat);
        pulse_done(1, 1, 0, "s1_b2");
        check("s1_idle", busy, 0);
        check("s1_launches", launch_cnt, 2);

        // 2: tie after reset, message lock, then round-robin tie to req1
        apply_reset();
        base = launch_cnt;
        push(1'b0, 8'hA1);
        send_both(8'hA1, 8'hB1);
        wait_launch(base + 1, lat);
        pulse_done(1, 1, 0, "s2_a1");
        check("s2_lock", launch_cnt, base + 1);
        push(1'b0, 8'hA2);
        send1(0, 8'hA2);
        wait_launch(base + 2, lat);
        send1(0, 8'hA3);
        push(1'b1, 8'hB1);
        pulse_done(1, 1, 0, "s2_a2");
        wait_launch(base + 3, lat);
        pulse_done(1, 0, 1, "s2_b1");
        check("s2_lock_b", launch_cnt, base + 3);
        push(1'b1, 8'hB2);
        send1(1, 8'hB2);
        wait_launch(base + 4, lat);
        push(1'b0, 8'hA3);
        pulse_done(1, 0, 1, "s2_b2");
        wait_launch(base + 5, lat);
        pulse_done(1, 1, 0, "s2_a3");
        check("s2_overflow", overflow, 0);

        // 3: req1 byte arriving mid-message waits for req0's second byte
        apply_reset();
        base = launch_cnt;
        push(1'b0, 8'hD1);
        send1(0, 8'hD1);
        wait_launch(base + 1, lat);
        pulse_done(1, 1, 0, "s3_d1");
        send1(1, 8'hC0);
        repeat (4) @(negedge clk);
        #1;
        check("s3_c0_held", launch_cnt, base + 1);
        push(1'b0, 8'hD2);
        push(1'b1, 8'hC0);
        send1(0, 8'hD2);
        wait_launch(base + 2, lat);
        pulse_done(1, 1, 0, "s3_d2");
        wait_launch(base + 3, lat);
        check("s3_overflow", overflow, 0);
        pulse_done(1, 0, 1, "s3_c0");

        // 4: back-to-back sends before the first launch overflow the slot
        apply_reset();
        base = launch_cnt;
        push(1'b0, 8'hE1);
        @(negedge clk);
        req0_send = 1'b1;
        req0_byte = 8'hE1;
        @(negedge clk);
        req0_byte = 8'hE2;
        @(negedge clk);
        req0_send = 1'b0;
        wait_launch(base + 1, lat);
        check("s4_overflow_set", overflow, 1);
        pulse_done(1, 1, 0, "s4_e1");
        push(1'b0, 8'hE3);
        send1(0, 8'hE3);
        wait_launch(base + 2, lat);
        pulse_done(1, 1, 0, "s4_e3");
        check("s4_e2_dropped", launch_cnt, base + 2);
        check("s4_overflow_sticky", overflow, 1);
        apply_reset();
        #1;
        check("s4_overflow_cleared", overflow, 0);

        // 5: held-high tx_done counts once; spurious edges are ignored
        base = launch_cnt;
        push(1'b1, 8'hF1);
        send1(1, 8'hF1);
        wait_launch(base + 1, lat);
        pulse_done(2, 0, 1, "s5_hold");
        pulse_done(1, 0, 0, "s5_spurious_next");
        push(1'b1, 8'hF2);
        send1(1, 8'hF2);
        wait_launch(base + 2, lat);
        pulse_done(1, 0, 1, "s5_f2");
        check("s5_idle", busy, 0);
        pulse_done(1, 0, 0, "s5_spurious_idle");
        check("s5_no_launch", launch_cnt, base + 2);

        // 6: asynchronous reset while waiting for done
        base = launch_cnt;
        push(1'b0, 8'h61);
        send1(0, 8'h61);
        wait_launch(base + 1, lat);
        send1(1, 8'h62);
        #2;
        rst = 1'b1;
        #1;
        check("s6_async_busy", busy, 0);
        check("s6_async_tx", {tx_send, tx_byte}, 0);
        check("s6_async_done", {req1_done, req0_done}, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        #1;
        check("s6_pending_dropped", launch_cnt, base + 1);
        push(1'b1, 8'h63);
        send1(1, 8'h63);
        wait_launch(base + 2, lat);
        pulse_done(1, 0, 1, "s6_after_rst");

        check("queue_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
